// File: rtl/iic_arbiter_if.sv
// Bundle between the requesters, the arbiter and the IIC_module engine.
// master: the arbiter (drives responses to requesters and commands to the engine).
// slave:  the surroundings (requesters plus engine).
`timescale 1ns/1ps
interface iic_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [2*N_REQ-1:0] req_call;
    logic [8*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   resp_done;
    logic [N_REQ-1:0]   resp_err;
    logic [7:0]         resp_rdata;
    logic [N_REQ-1:0]   grant;
    logic [1:0]         m_call;
    logic [7:0]         m_addr;
    logic [7:0]         m_wdata;
    logic [7:0]         m_rdata;
    logic               m_done;

    modport master (
        input  req_call, req_addr, req_wdata, m_rdata, m_done,
        output resp_done, resp_err, resp_rdata, grant, m_call, m_addr, m_wdata
    );

    modport slave (
        output req_call, req_addr, req_wdata, m_rdata, m_done,
        input  resp_done, resp_err, resp_rdata, grant, m_call, m_addr, m_wdata
    );
endinterface

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one IIC_module byte engine between N_REQ requesters.
// Holds the engine call until done (or watchdog abort), then forces one idle cycle.
//
// state | meaning
// IDLE  | no owner; search pending requesters from ptr upward and latch the winner
// BUSY  | engine call driven for the owner; watchdog counting down
// GAP   | one cycle with call and grant low so the engine returns to idle
`timescale 1ns/1ps
module iic_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    iic_arbiter_if.master  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  owner_next;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [N_REQ-1:0]  pending;
    logic [1:0]        pick_call;
    logic [7:0]        pick_addr;
    logic [7:0]        pick_wdata;
    logic [CNT_W-1:0]  wdog;
    logic              cmd_rd;

    // A requester is pending whenever either of its call bits is set.
    always_comb begin
        pending = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pending[k] = |bus.req_call[2*k +: 2];
        end
    end

    // First pending requester searching upward from ptr with wrap-around.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_valid && pending[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = PTR_W'(cand);
            end
        end
    end

    // Fields of the winning requester, plus the pointer value after the current owner.
    always_comb begin
        pick_call  = bus.req_call[2*pick_idx +: 2];
        pick_addr  = bus.req_addr[8*pick_idx +: 8];
        pick_wdata = bus.req_wdata[8*pick_idx +: 8];
        owner_next = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
    end

    // Arbitration FSM; every output is a register. m_done wins over the last watchdog count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            wdog           <= '0;
            cmd_rd         <= 1'b0;
            bus.grant      <= '0;
            bus.m_call     <= 2'b00;
            bus.m_addr     <= '0;
            bus.m_wdata    <= '0;
            bus.resp_rdata <= '0;
            bus.resp_done  <= '0;
            bus.resp_err   <= '0;
        end else begin
            bus.resp_done <= '0;
            bus.resp_err  <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_idx;
                        bus.grant   <= N_REQ'(1) << pick_idx;
                        bus.m_addr  <= pick_addr;
                        bus.m_wdata <= pick_wdata;
                        // call = 11 is treated as a write
                        bus.m_call  <= pick_call[1] ? 2'b10 : 2'b01;
                        cmd_rd      <= ~pick_call[1];
                        wdog        <= CNT_W'(TIMEOUT_CYC - 1);
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.m_done) begin
                        if (cmd_rd) begin
                            bus.resp_rdata <= bus.m_rdata;
                        end
                        bus.resp_done <= bus.grant;
                        bus.grant     <= '0;
                        bus.m_call    <= 2'b00;
                        ptr           <= owner_next;
                        wdog          <= '0;
                        state         <= GAP;
                    end else if (wdog == '0) begin
                        bus.resp_done <= bus.grant;
                        bus.resp_err  <= bus.grant;
                        bus.grant     <= '0;
                        bus.m_call    <= 2'b00;
                        ptr           <= owner_next;
                        state         <= GAP;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    bus.grant  <= '0;
                    bus.m_call <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iic_arbiter.sv
// Scoreboard bench for iic_arbiter: expected grants and responses are queued as
// stimulus is applied and popped when the DUT raises grant / resp_done.
`timescale 1ns/1ps
module tb_iic_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iic_arbiter_if #(.N_REQ(N)) bus ();

    iic_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         idx;
        logic [1:0] call;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         b2b;
    } gnt_t;

    typedef struct {
        int         idx;
        bit         err;
        logic [7:0] rdata;
        int         lat;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         grant_cyc = 0;
    int         done_cyc  = -100;
    logic [N-1:0] prev_grant = '0;
    bit         pulse_chk = 1'b0;
    logic [7:0] last_rd   = 8'h00;

    bit         eng_en  = 1'b1;
    int         eng_lat = 4;
    logic [7:0] eng_xor = 8'h00;
    int         eng_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
        bus.req_call[2*k +: 2]  = c;
        bus.req_addr[8*k +: 8]  = a;
        bus.req_wdata[8*k +: 8] = d;
    endtask

    task automatic push_g(input int k, input logic [1:0] c, input logic [7:0] a, input logic [7:0] d, input bit b2b);
        gnt_t g;
        g.idx = k; g.call = c; g.addr = a; g.wdata = d; g.b2b = b2b;
        gnt_q.push_back(g);
    endtask

    task automatic push_r(input int k, input bit err, input int lat, input bit is_rd, input logic [7:0] rd);
        rsp_t r;
        if (!err && is_rd) last_rd = rd;
        r.idx = k; r.err = err; r.rdata = last_rd; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (gnt_q.size() == 0 && rsp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_grant_q", gnt_q.size(), 0);
        chk("drain_resp_q", rsp_q.size(), 0);
        gnt_q.delete();
        rsp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  bus.grant, 0);
        chk({tag, "_m_call"}, bus.m_call, 0);
        chk({tag, "_m_addr"}, bus.m_addr, 0);
        chk({tag, "_m_wdata"}, bus.m_wdata, 0);
        chk({tag, "_rdata"},  bus.resp_rdata, 0);
        chk({tag, "_done"},   bus.resp_done, 0);
        chk({tag, "_err"},    bus.resp_err, 0);
    endtask

    // Engine model: native handshake, m_done pulses eng_lat cycles after call rises.
    always @(negedge clk) begin
        bus.m_done = 1'b0;
        if (bus.m_call != 2'b00) begin
            eng_cnt++;
            if (eng_en && eng_cnt == eng_lat) begin
                bus.m_done  = 1'b1;
                bus.m_rdata = bus.m_addr ^ eng_xor;
            end
        end else begin
            eng_cnt = 0;
        end
    end

    // Monitor: pops expectations on grant rise and on resp_done, and drops served requests.
    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        cyc++;
        if (!rst_n) begin
            prev_grant = '0;
            pulse_chk  = 1'b0;
        end else begin
            if (pulse_chk) begin
                chk("done_pulse_width", bus.resp_done, 0);
                pulse_chk = 1'b0;
            end
            if (bus.grant != '0 && prev_grant == '0) begin
                if (gnt_q.size() == 0) begin
                    chk("grant_unexpected", bus.grant, 0);
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant",   bus.grant, 32'd1 << g.idx);
                    chk("m_call",  bus.m_call, g.call);
                    chk("m_addr",  bus.m_addr, g.addr);
                    chk("m_wdata", bus.m_wdata, g.wdata);
                    if (g.b2b) chk("b2b_spacing", cyc - done_cyc, 2);
                end
                grant_cyc = cyc;
            end
            prev_grant = bus.grant;
            if (bus.resp_done != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("done_unexpected", bus.resp_done, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("resp_done",  bus.resp_done, 32'd1 << r.idx);
                    chk("resp_err",   bus.resp_err, r.err ? (32'd1 << r.idx) : 32'd0);
                    chk("resp_rdata", bus.resp_rdata, r.rdata);
                    chk("latency",    cyc - grant_cyc, r.lat);
                end
                chk("gap_m_call", bus.m_call, 0);
                chk("gap_grant",  bus.grant, 0);
                done_cyc  = cyc;
                pulse_chk = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (bus.resp_done[k]) bus.req_call[2*k +: 2] = 2'b00;
                end
            end else if (bus.resp_err != '0) begin
                chk("err_without_done", bus.resp_err, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got t=%0t expected completion earlier", $time);
        $fatal(1, "time limit");
    end

    initial begin
        bus.req_call  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_done    = 1'b0;
        bus.m_rdata   = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write from requester 0
        eng_lat = 12; eng_xor = 8'h00;
        push_g(0, 2'b10, 8'h00, 8'hAB, 1'b0);
        push_r(0, 1'b0, 12, 1'b0, 8'h00);
        set_req(0, 2'b10, 8'h00, 8'hAB);
        drain(100);

        // Read return from requester 2, then a write that must not disturb resp_rdata
        eng_lat = 5; eng_xor = 8'hED;
        push_g(2, 2'b01, 8'h02, 8'h55, 1'b0);
        push_r(2, 1'b0, 5, 1'b1, 8'hEF);
        set_req(2, 2'b01, 8'h02, 8'h55);
        drain(100);
        push_g(3, 2'b10, 8'h33, 8'h44, 1'b0);
        push_r(3, 1'b0, 5, 1'b0, 8'h00);
        set_req(3, 2'b10, 8'h33, 8'h44);
        drain(100);

        // Round-robin with all four pending (ptr back at 0); requester 2 uses call=11
        eng_lat = 3; eng_xor = 8'h00;
        push_g(0, 2'b01, 8'hA0, 8'hB0, 1'b0); push_r(0, 1'b0, 3, 1'b1, 8'hA0);
        push_g(1, 2'b10, 8'hA1, 8'hB1, 1'b1); push_r(1, 1'b0, 3, 1'b0, 8'h00);
        push_g(2, 2'b10, 8'hA2, 8'hB2, 1'b1); push_r(2, 1'b0, 3, 1'b0, 8'h00);
        push_g(3, 2'b01, 8'hA3, 8'hB3, 1'b1); push_r(3, 1'b0, 3, 1'b1, 8'hA3);
        push_g(0, 2'b10, 8'hC0, 8'hD0, 1'b1); push_r(0, 1'b0, 3, 1'b0, 8'h00);
        bus.req_call = 8'b01_11_10_01;
        set_req(0, 2'b01, 8'hA0, 8'hB0);
        set_req(1, 2'b10, 8'hA1, 8'hB1);
        set_req(2, 2'b11, 8'hA2, 8'hB2);
        set_req(3, 2'b01, 8'hA3, 8'hB3);
        for (int i = 0; i < 100; i++) begin
            if (bus.grant[3]) break;
            @(negedge clk);
        end
        set_req(0, 2'b10, 8'hC0, 8'hD0);
        drain(200);

        // Watchdog abort on requester 1 (ptr = 1 after the last rotation)
        eng_en = 1'b0;
        push_g(1, 2'b10, 8'h77, 8'h88, 1'b0);
        push_r(1, 1'b1, TO, 1'b0, 8'h00);
        set_req(1, 2'b10, 8'h77, 8'h88);
        drain(100);

        // ptr advanced past 1: requester 2 wins over 1; m_done on the last count is a normal completion
        eng_en = 1'b1; eng_lat = TO; eng_xor = 8'h00;
        push_g(2, 2'b01, 8'h12, 8'h34, 1'b0); push_r(2, 1'b0, TO, 1'b1, 8'h12);
        push_g(1, 2'b10, 8'h21, 8'h43, 1'b1); push_r(1, 1'b0, TO, 1'b0, 8'h00);
        set_req(1, 2'b10, 8'h21, 8'h43);
        set_req(2, 2'b01, 8'h12, 8'h34);
        drain(200);

        // Reset in the middle of a hung transfer from requester 3
        eng_en = 1'b0;
        push_g(3, 2'b10, 8'h5A, 8'hA5, 1'b0);
        set_req(3, 2'b10, 8'h5A, 8'hA5);
        for (int i = 0; i < 20; i++) begin
            if (bus.grant[3]) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("busy_before_reset", bus.m_call, 2'b10);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        gnt_q.delete();
        rsp_q.delete();
        last_rd = 8'h00;
        set_req(1, 2'b10, 8'h61, 8'h16);
        eng_en = 1'b1; eng_lat = 4;
        push_g(1, 2'b10, 8'h61, 8'h16, 1'b0); push_r(1, 1'b0, 4, 1'b0, 8'h00);
        push_g(3, 2'b10, 8'h5A, 8'hA5, 1'b1); push_r(3, 1'b0, 4, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
